// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe
//   Pipelined Kogge-Stone parallel-prefix adder computing a + b + cin with a
//   valid/ready stream interface. One result per cycle, full backpressure,
//   and bubble collapse: an empty rank refills even while the output stalls.
//
//   Ranks: rank 0 captures bitwise p/g (cin folded into bit-0 generate).
//   A prefix rank follows every PIPE_EVERY levels, except after the last level.
//   The final rank registers sum/cout/ovf/grp_p.
//   Latency = 2 + (LOG2W-1)/PIPE_EVERY cycles.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (a, b, cin)
//   out_valid/out_ready result handshake (sum, cout, ovf, grp_p)
//   sum   (a+b+cin) mod 2^WIDTH
//   cout  carry out of bit WIDTH-1
//   ovf   carry into MSB xor cout
//   grp_p AND of all bitwise propagates
module prefix_adder_pipe #(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             grp_p
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int NMID  = (LOG2W - 1) / PIPE_EVERY;  // prefix ranks after rank 0
  localparam int NPFX  = NMID + 1;                  // ranks holding prefix state
  localparam int NRANK = NMID + 2;                  // including output rank
  localparam int LAST  = NRANK - 1;

  // Prefix-rank storage: group g/p, raw bitwise p (for the sum) and cin.
  logic [WIDTH-1:0] rg_q [NPFX];
  logic [WIDTH-1:0] rp_q [NPFX];
  logic [WIDTH-1:0] rx_q [NPFX];
  logic [NPFX-1:0]  rc_q;

  logic [NRANK-1:0] v_q, v_d;
  logic [NRANK-1:0] load_s, adv_s, rdy_s;
  logic             init_q;

  logic [WIDTH-1:0] p0_s, g0_s;
  logic [WIDTH-1:0] lg_s [1:LOG2W];
  logic [WIDTH-1:0] lp_s [1:LOG2W];

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, grp_d, grp_q;

  // Stage 0 bitwise propagate/generate with cin folded into bit 0.
  always_comb begin
    p0_s    = a ^ b;
    g0_s    = a & b;
    g0_s[0] = (a[0] & b[0]) | (p0_s[0] & cin);
  end

  // Prefix levels; level k reads from a register rank when one precedes it.
  for (genvar k = 1; k <= LOG2W; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    logic [WIDTH-1:0] gi_s, pi_s, go_s, po_s;

    if (((k - 1) % PIPE_EVERY) == 0) begin : g_from_reg
      assign gi_s = rg_q[(k - 1) / PIPE_EVERY];
      assign pi_s = rp_q[(k - 1) / PIPE_EVERY];
    end else begin : g_from_comb
      assign gi_s = lg_s[k - 1];
      assign pi_s = lp_s[k - 1];
    end

    // Combine bit i with bit i-D; bits below D pass through.
    always_comb begin
      go_s = gi_s;
      po_s = pi_s;
      for (int i = D; i < WIDTH; i++) begin
        go_s[i] = gi_s[i] | (pi_s[i] & gi_s[i - D]);
        po_s[i] = pi_s[i] & pi_s[i - D];
      end
    end

    assign lg_s[k] = go_s;
    assign lp_s[k] = po_s;
  end

  // Handshake chain: readiness ripples back from out_ready through each rank.
  always_comb begin
    logic rdy_nxt;
    adv_s   = '0;
    rdy_s   = '0;
    load_s  = '0;
    rdy_nxt = out_ready;
    for (int r = LAST; r >= 0; r--) begin
      adv_s[r] = v_q[r] & rdy_nxt;
      rdy_s[r] = ~v_q[r] | adv_s[r];
      rdy_nxt  = rdy_s[r];
    end
    load_s[0] = in_valid & init_q & rdy_s[0];
    for (int r = 1; r < NRANK; r++) begin
      load_s[r] = v_q[r - 1] & rdy_s[r];
    end
  end

  // Next-state of every rank valid bit.
  always_comb begin
    v_d = v_q;
    for (int r = 0; r < NRANK; r++) begin
      if (load_s[r]) begin
        v_d[r] = 1'b1;
      end else if (adv_s[r]) begin
        v_d[r] = 1'b0;
      end else begin
        v_d[r] = v_q[r];
      end
    end
  end

  // Output rank next values from the fully resolved prefix.
  always_comb begin
    sum_d  = {rx_q[NMID][WIDTH-1:1] ^ lg_s[LOG2W][WIDTH-2:0],
              rx_q[NMID][0] ^ rc_q[NMID]};
    cout_d = lg_s[LOG2W][WIDTH-1];
    ovf_d  = lg_s[LOG2W][WIDTH-1] ^ lg_s[LOG2W][WIDTH-2];
    // Every bit's group propagate spans down to bit 0, so their AND is &p.
    grp_d  = &lp_s[LOG2W];
  end

  // Valid bits and the post-reset accept enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      init_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      init_q <= 1'b1;
    end
  end

  // Prefix-rank data registers; qualified by load only, no reset needed.
  always_ff @(posedge clk) begin
    if (load_s[0]) begin
      rg_q[0] <= g0_s;
      rp_q[0] <= p0_s;
      rx_q[0] <= p0_s;
      rc_q[0] <= cin;
    end
    for (int j = 1; j < NPFX; j++) begin
      if (load_s[j]) begin
        rg_q[j] <= lg_s[j * PIPE_EVERY];
        rp_q[j] <= lp_s[j * PIPE_EVERY];
        rx_q[j] <= rx_q[j - 1];
        rc_q[j] <= rc_q[j - 1];
      end
    end
  end

  // Output rank; reset so the result pins read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      grp_q  <= 1'b0;
    end else if (load_s[LAST]) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      grp_q  <= grp_d;
    end
  end

  assign in_ready  = init_q & rdy_s[0];
  assign out_valid = v_q[LAST];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign grp_p     = grp_q;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed bench for prefix_adder_pipe: reset state, hand-computed vectors,
// random streams, backpressure, mid-stream reset, and several geometries.
module tb_prefix_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [4:0]   iv_r;
  logic         ordy_r;
  logic [127:0] a_r, b_r;
  logic         cin_r;

  wire  [4:0]   ir_w, ov_w, co_w, of_w, gp_w;
  wire  [31:0]  s0;
  wire  [7:0]   s1, s2;
  wire  [63:0]  s3;
  wire  [127:0] s4;
  logic [127:0] s_w [5];

  always_comb begin
    s_w[0] = {96'd0, s0};
    s_w[1] = {120'd0, s1};
    s_w[2] = {120'd0, s2};
    s_w[3] = {64'd0, s3};
    s_w[4] = s4;
  end

  prefix_adder_pipe #(.WIDTH(32), .PIPE_EVERY(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_r[0]), .in_ready(ir_w[0]),
    .a(a_r[31:0]), .b(b_r[31:0]), .cin(cin_r), .out_valid(ov_w[0]),
    .out_ready(ordy_r), .sum(s0), .cout(co_w[0]), .ovf(of_w[0]), .grp_p(gp_w[0]));
  prefix_adder_pipe #(.WIDTH(8), .PIPE_EVERY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_r[1]), .in_ready(ir_w[1]),
    .a(a_r[7:0]), .b(b_r[7:0]), .cin(cin_r), .out_valid(ov_w[1]),
    .out_ready(ordy_r), .sum(s1), .cout(co_w[1]), .ovf(of_w[1]), .grp_p(gp_w[1]));
  prefix_adder_pipe #(.WIDTH(8), .PIPE_EVERY(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_r[2]), .in_ready(ir_w[2]),
    .a(a_r[7:0]), .b(b_r[7:0]), .cin(cin_r), .out_valid(ov_w[2]),
    .out_ready(ordy_r), .sum(s2), .cout(co_w[2]), .ovf(of_w[2]), .grp_p(gp_w[2]));
  prefix_adder_pipe #(.WIDTH(64), .PIPE_EVERY(6)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_r[3]), .in_ready(ir_w[3]),
    .a(a_r[63:0]), .b(b_r[63:0]), .cin(cin_r), .out_valid(ov_w[3]),
    .out_ready(ordy_r), .sum(s3), .cout(co_w[3]), .ovf(of_w[3]), .grp_p(gp_w[3]));
  prefix_adder_pipe #(.WIDTH(128), .PIPE_EVERY(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_r[4]), .in_ready(ir_w[4]),
    .a(a_r), .b(b_r), .cin(cin_r), .out_valid(ov_w[4]),
    .out_ready(ordy_r), .sum(s4), .cout(co_w[4]), .ovf(of_w[4]), .grp_p(gp_w[4]));

  typedef struct {
    logic [127:0] s;
    logic         c;
    logic         o;
    logic         g;
    int           t;
  } exp_t;

  exp_t q[$];
  int   wid [5] = '{32, 8, 8, 64, 128};
  int   lat [5] = '{4, 4, 2, 2, 5};   // 2 + (log2(W)-1)/PIPE_EVERY
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   popped = 0;
  int   acc = 0;
  bit   chk_lat = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide addition, independent of any prefix structure.
  function automatic exp_t model(input int c, input logic [127:0] a, input logic [127:0] b,
                                 input logic ci);
    exp_t         r;
    logic [128:0] full;
    logic [127:0] m;
    m    = {128{1'b1}} >> (128 - wid[c]);
    full = {1'b0, a & m} + {1'b0, b & m} + {128'd0, ci};
    r.s  = full[127:0] & m;
    r.c  = full[wid[c]];
    r.o  = (a[wid[c]-1] == b[wid[c]-1]) && (r.s[wid[c]-1] != a[wid[c]-1]);
    r.g  = &((a ^ b) | ~m);
    r.t  = 0;
    return r;
  endfunction

  // One cycle on config c: record accepted beat, check any delivered result.
  task automatic step(input int c);
    exp_t e, x;
    #1;
    if (iv_r[c] && ir_w[c]) begin
      e   = model(c, a_r, b_r, cin_r);
      e.t = cyc_n;
      q.push_back(e);
    end
    if (ov_w[c] && ordy_r) begin
      if (q.size() == 0) begin
        chk("spurious_out", {127'd0, ov_w[c]}, 128'd0);
      end else begin
        x = q.pop_front();
        chk("sum", s_w[c], x.s);
        chk("cout", {127'd0, co_w[c]}, {127'd0, x.c});
        chk("ovf", {127'd0, of_w[c]}, {127'd0, x.o});
        chk("grp_p", {127'd0, gp_w[c]}, {127'd0, x.g});
        if (chk_lat) chk("latency", cyc_n - x.t, lat[c]);
        popped++;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic hchk(input string tag, input logic [31:0] es, input logic ec,
                      input logic eo, input logic eg);
    chk({tag, "_valid"}, {127'd0, ov_w[0]}, 128'd1);
    chk({tag, "_sum"}, s_w[0], {96'd0, es});
    chk({tag, "_cout"}, {127'd0, co_w[0]}, {127'd0, ec});
    chk({tag, "_ovf"}, {127'd0, of_w[0]}, {127'd0, eo});
    chk({tag, "_grp"}, {127'd0, gp_w[0]}, {127'd0, eg});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_stream(input int c, input int n);
    popped  = 0;
    chk_lat = 1'b1;
    ordy_r  = 1'b1;
    for (int i = 0; i < n; i++) begin
      a_r      = {$urandom(), $urandom(), $urandom(), $urandom()};
      b_r      = {$urandom(), $urandom(), $urandom(), $urandom()};
      cin_r    = 1'($urandom_range(0, 1));
      iv_r[c]  = 1'b1;
      #1;
      chk("in_ready_stream", {127'd0, ir_w[c]}, 128'd1);
      step(c);
    end
    iv_r[c] = 1'b0;
    for (int i = 0; i < 10; i++) step(c);
    chk("stream_count", popped, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    iv_r   = '0;
    ordy_r = 1'b1;
    a_r    = '0;
    b_r    = '0;
    cin_r  = 1'b0;

    // Reset state.
    #2;
    chk("rst_out_valid", {127'd0, ov_w[0]}, 128'd0);
    chk("rst_sum", s_w[0], 128'd0);
    chk("rst_cout", {127'd0, co_w[0]}, 128'd0);
    chk("rst_ovf", {127'd0, of_w[0]}, 128'd0);
    chk("rst_grp", {127'd0, gp_w[0]}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_rst", {127'd0, ir_w[0]}, 128'd1);

    // Directed vectors, one per cycle.
    iv_r[0] = 1'b1;
    a_r = 128'hFFFF_FFFF; b_r = 128'h0; cin_r = 1'b1;
    tick();
    a_r = 128'h7FFF_FFFF; b_r = 128'h1; cin_r = 1'b0;
    tick();
    a_r = 128'h8000_0000; b_r = 128'h8000_0000; cin_r = 1'b0;
    tick();
    a_r = 128'h1234_5678; b_r = 128'h9ABC_DEF0; cin_r = 1'b1;
    #1;
    chk("lat_not_early", {127'd0, ov_w[0]}, 128'd0);
    tick();
    iv_r[0] = 1'b0;
    #1;
    hchk("v0", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    tick();
    hchk("v1", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tick();
    hchk("v2", 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    tick();
    hchk("v3", 32'hACF1_3569, 1'b0, 1'b0, 1'b0);
    tick();
    chk("idle_after_vectors", {127'd0, ov_w[0]}, 128'd0);

    // Random back-to-back stream, WIDTH=32.
    rand_stream(0, 100);

    // Backpressure: output stalled for 10 cycles while offering beats.
    chk_lat = 1'b0;
    popped  = 0;
    acc     = 0;
    ordy_r  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iv_r[0] = 1'b1;
      a_r     = 128'h1000_0000 + 128'(acc);
      b_r     = 128'(acc * 3);
      cin_r   = 1'(acc & 1);
      #1;
      if (ir_w[0]) acc++;
      if (ov_w[0] && q.size() > 0) chk("stall_hold_sum", s_w[0], q[0].s);
      step(0);
    end
    chk("stall_accept_count", acc, 4);
    chk("stall_in_ready", {127'd0, ir_w[0]}, 128'd0);
    chk("stall_out_valid", {127'd0, ov_w[0]}, 128'd1);
    iv_r[0] = 1'b0;
    ordy_r  = 1'b1;
    for (int i = 0; i < 8; i++) step(0);
    chk("stall_drain_count", popped, 4);

    // Reset with three beats in flight.
    chk_lat = 1'b1;
    popped  = 0;
    for (int i = 0; i < 3; i++) begin
      iv_r[0] = 1'b1;
      a_r = 128'h0F0F_0F0F + 128'(i); b_r = 128'h3; cin_r = 1'b1;
      step(0);
    end
    iv_r[0] = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, ov_w[0]}, 128'd0);
    chk("midrst_sum", s_w[0], 128'd0);
    chk("midrst_cout", {127'd0, co_w[0]}, 128'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    iv_r[0] = 1'b1;
    a_r = 128'h0000_FFFF; b_r = 128'h1; cin_r = 1'b0;
    step(0);
    iv_r[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ov_w[0]) chk("post_rst_sum_hand", s_w[0], 128'h0001_0000);
      step(0);
    end
    chk("post_rst_count", popped, 1);

    // Other geometries.
    for (int c = 1; c < 5; c++) rand_stream(c, 100);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
